// File: rtl/up_arbiter_pkg.sv
// Shared types and defaults for the two-port uP bus arbiter.
package up_arbiter_pkg;

   localparam int unsigned DEFAULT_ADDRESS_WIDTH  = 14;
   localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
   localparam logic [31:0] DEFAULT_TIMEOUT_DATA   = 32'hDEAD_DEAD;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_ACK,
      ST_HOLD
   } state_t;

   // Timeout counter width; a disabled timeout still needs a legal 1-bit vector.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles == 0) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/up_arbiter_if.sv
// One uP read/write bus; the master modport drives requests, the slave modport drives acks.
interface up_arbiter_if
   import up_arbiter_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH
);
   logic                     rreq;
   logic [ADDRESS_WIDTH-1:0] raddr;
   logic                     rack;
   logic [DATA_WIDTH-1:0]    rdata;
   logic                     wreq;
   logic [ADDRESS_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0]    wdata;
   logic                     wack;

   modport master (
      output rreq, raddr, wreq, waddr, wdata,
      input  rack, rdata, wack
   );

   modport slave (
      input  rreq, raddr, wreq, waddr, wdata,
      output rack, rdata, wack
   );
endinterface

// File: rtl/up_arbiter_rr2.sv
// Two-requester round-robin picker: on a tie the port that did not win the last tie is chosen.
module up_arbiter_rr2
   import up_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   output logic       o_grant_c,
   output logic       o_valid_c
);

   always_comb begin
      o_valid_c = |i_req;
      o_grant_c = PORT0;
      unique case (i_req)
         2'b01:   o_grant_c = PORT0;
         2'b10:   o_grant_c = PORT1;
         2'b11:   o_grant_c = ~i_last_grant;
         default: o_grant_c = PORT0;
      endcase
   end

endmodule

// File: rtl/up_arbiter.sv
// Shares one uP register slave between two uP masters: round-robin grant,
// one outstanding access, registered forwarding and a bus timeout.
module up_arbiter
   import up_arbiter_pkg::*;
#(
   parameter int unsigned           ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
   parameter int unsigned           DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int unsigned           TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(DEFAULT_TIMEOUT_DATA)
)(
   input  logic         clk,
   input  logic         rst,
   up_arbiter_if.slave  s0_up,
   up_arbiter_if.slave  s1_up,
   up_arbiter_if.master m_up,
   output logic         timeout
);

   localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

   state_t                   r_state;
   logic                     r_last_grant;
   logic                     r_grant;
   logic                     r_is_read;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_m_rreq;
   logic                     r_m_wreq;
   logic [ADDRESS_WIDTH-1:0] r_m_raddr;
   logic [ADDRESS_WIDTH-1:0] r_m_waddr;
   logic [DATA_WIDTH-1:0]    r_m_wdata;
   logic [1:0]               r_s_rack;
   logic [1:0]               r_s_wack;
   logic [DATA_WIDTH-1:0]    r_s0_rdata;
   logic [DATA_WIDTH-1:0]    r_s1_rdata;
   logic                     r_timeout;

   logic [1:0]               w_req;
   logic                     w_grant;
   logic                     w_valid;
   logic                     w_tie;
   logic                     w_sel_rreq;
   logic [ADDRESS_WIDTH-1:0] w_sel_raddr;
   logic [ADDRESS_WIDTH-1:0] w_sel_waddr;
   logic [DATA_WIDTH-1:0]    w_sel_wdata;
   logic                     w_ack;
   logic                     w_expire;
   logic [DATA_WIDTH-1:0]    w_rdata_next;

   assign w_req = {s1_up.rreq | s1_up.wreq, s0_up.rreq | s0_up.wreq};
   assign w_tie = &w_req;

   up_arbiter_rr2 u_rr2 (
      .i_req        (w_req),
      .i_last_grant (r_last_grant),
      .o_grant_c    (w_grant),
      .o_valid_c    (w_valid)
   );

   // Request fields of the port being granted; read wins within a port.
   assign w_sel_rreq  = (w_grant == PORT1) ? s1_up.rreq  : s0_up.rreq;
   assign w_sel_raddr = (w_grant == PORT1) ? s1_up.raddr : s0_up.raddr;
   assign w_sel_waddr = (w_grant == PORT1) ? s1_up.waddr : s0_up.waddr;
   assign w_sel_wdata = (w_grant == PORT1) ? s1_up.wdata : s0_up.wdata;

   assign w_ack        = r_is_read ? m_up.rack : m_up.wack;
   assign w_expire     = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_rdata_next = w_ack ? m_up.rdata : TIMEOUT_DATA;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= PORT1;
         r_grant      <= PORT0;
         r_is_read    <= 1'b0;
         r_cnt        <= '0;
         r_m_rreq     <= 1'b0;
         r_m_wreq     <= 1'b0;
         r_m_raddr    <= '0;
         r_m_waddr    <= '0;
         r_m_wdata    <= '0;
         r_s_rack     <= '0;
         r_s_wack     <= '0;
         r_s0_rdata   <= '0;
         r_s1_rdata   <= '0;
         r_timeout    <= 1'b0;
      end else begin
         r_s_rack  <= '0;
         r_s_wack  <= '0;
         r_timeout <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_grant   <= w_grant;
                  r_is_read <= w_sel_rreq;
                  r_cnt     <= '0;
                  if (w_tie) r_last_grant <= w_grant;
                  if (w_sel_rreq) begin
                     r_m_rreq  <= 1'b1;
                     r_m_raddr <= w_sel_raddr;
                  end else begin
                     r_m_wreq  <= 1'b1;
                     r_m_waddr <= w_sel_waddr;
                     r_m_wdata <= w_sel_wdata;
                  end
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // A slave ack landing on the last allowed cycle beats the timeout.
               if (w_ack || w_expire) begin
                  r_m_rreq  <= 1'b0;
                  r_m_wreq  <= 1'b0;
                  r_timeout <= ~w_ack;
                  if (r_is_read) begin
                     r_s_rack[r_grant] <= 1'b1;
                     if (r_grant == PORT1) r_s1_rdata <= w_rdata_next;
                     else                  r_s0_rdata <= w_rdata_next;
                  end else begin
                     r_s_wack[r_grant] <= 1'b1;
                  end
                  r_state <= ST_ACK;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_ACK:  r_state <= ST_HOLD;
            ST_HOLD: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign m_up.rreq  = r_m_rreq;
   assign m_up.wreq  = r_m_wreq;
   assign m_up.raddr = r_m_raddr;
   assign m_up.waddr = r_m_waddr;
   assign m_up.wdata = r_m_wdata;

   assign s0_up.rack  = r_s_rack[0];
   assign s0_up.wack  = r_s_wack[0];
   assign s0_up.rdata = r_s0_rdata;
   assign s1_up.rack  = r_s_rack[1];
   assign s1_up.wack  = r_s_wack[1];
   assign s1_up.rdata = r_s1_rdata;

   assign timeout = r_timeout;

endmodule

// File: tb/tb_up_arbiter.sv
// Directed and random bench for up_arbiter with an 8-cycle bus timeout.
module tb_up_arbiter;
   import up_arbiter_pkg::*;

   localparam int unsigned AW     = 14;
   localparam int unsigned DW     = 32;
   localparam int unsigned T_CYC  = 8;
   localparam int unsigned N_RAND = 15;
   localparam logic [31:0] TDATA  = 32'hDEAD_DEAD;

   logic clk = 1'b0;
   logic rst;
   logic timeout;

   int n_asserts = 0;
   int n_fail    = 0;
   bit rand_done   = 1'b0;
   bit slv_exp_tmo = 1'b0;
   int mon_bad  = 0;
   int mon_ack0 = 0;
   int mon_ack1 = 0;

   up_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) s0_if ();
   up_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) s1_if ();
   up_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

   up_arbiter #(
      .ADDRESS_WIDTH  (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (T_CYC),
      .TIMEOUT_DATA   (TDATA)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s0_up   (s0_if),
      .s1_up   (s1_if),
      .m_up    (m_if),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] out_flags();
      return 64'({m_if.rreq, m_if.wreq, timeout, s0_if.rack, s0_if.wack, s1_if.rack, s1_if.wack});
   endfunction

   // Waits (bounded) for the forwarded request, checks it, then acks after wait_cyc extra cycles.
   // Returns in the cycle where the port ack is expected.
   task automatic slave_ack(input string tag, input bit is_wr, input logic [13:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int wait_cyc);
      int n = 0;
      while (!(m_if.rreq || m_if.wreq) && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_mreq"}, 64'({m_if.wreq, m_if.rreq}), is_wr ? 64'd2 : 64'd1);
      chk({tag, "_maddr"}, 64'(is_wr ? m_if.waddr : m_if.raddr), 64'(addr));
      if (is_wr) chk({tag, "_mwdata"}, 64'(m_if.wdata), 64'(wd));
      repeat (wait_cyc) tick();
      m_if.rdata = rd;
      m_if.rack  = ~is_wr;
      m_if.wack  = is_wr;
      tick();
      m_if.rack = 1'b0;
      m_if.wack = 1'b0;
   endtask

   task automatic drive(input int p, input logic rd, input logic wr,
                        input logic [13:0] a, input logic [31:0] d);
      if (p == 0) begin
         s0_if.rreq = rd; s0_if.wreq = wr; s0_if.raddr = a; s0_if.waddr = a; s0_if.wdata = d;
      end else begin
         s1_if.rreq = rd; s1_if.wreq = wr; s1_if.raddr = a; s1_if.waddr = a; s1_if.wdata = d;
      end
   endtask

   task automatic get_ack(input int p, output logic gr, output logic gw, output logic [31:0] rdv);
      if (p == 0) begin gr = s0_if.rack; gw = s0_if.wack; rdv = s0_if.rdata; end
      else        begin gr = s1_if.rack; gw = s1_if.wack; rdv = s1_if.rdata; end
   endtask

   task automatic run_master(input int p);
      for (int t = 0; t < int'(N_RAND); t++) begin
         bit          wr  = 1'($urandom_range(0, 1));
         logic [13:0] a   = 14'($urandom);
         logic [31:0] d   = $urandom;
         bit          got = 1'b0;
         int          n   = 0;
         logic        gr, gw, tmo;
         logic [31:0] rdv;
         repeat ($urandom_range(0, 3)) tick();
         drive(p, ~wr, wr, a, d);
         gr = 1'b0; gw = 1'b0; rdv = '0; tmo = 1'b0;
         while (!got && n < 300) begin
            tick();
            n++;
            get_ack(p, gr, gw, rdv);
            if (gr || gw) begin
               got = 1'b1;
               tmo = timeout;
            end
         end
         drive(p, 1'b0, 1'b0, a, d);
         chk("rand_acked", 64'(got), 64'd1);
         chk("rand_kind", 64'({gw, gr}), wr ? 64'd2 : 64'd1);
         chk("rand_tmo", 64'(tmo), 64'(slv_exp_tmo));
         if (!wr) chk("rand_rdata", 64'(rdv), 64'(slv_exp_tmo ? TDATA : (32'(a) ^ 32'hA5A5_0000)));
      end
   endtask

   // Slave with random 1..20 cycle latency; it never acks a request the arbiter has withdrawn.
   task automatic slave_proc();
      int lat;
      while (!rand_done) begin
         tick();
         if (m_if.rreq || m_if.wreq) begin
            lat = $urandom_range(1, 20);
            slv_exp_tmo = (lat > int'(T_CYC));
            for (int i = 1; i < lat; i++) begin
               tick();
               if (!(m_if.rreq || m_if.wreq)) break;
            end
            if (m_if.rreq || m_if.wreq) begin
               m_if.rdata = 32'(m_if.raddr) ^ 32'hA5A5_0000;
               m_if.rack  = m_if.rreq;
               m_if.wack  = m_if.wreq;
               tick();
               m_if.rack = 1'b0;
               m_if.wack = 1'b0;
            end
         end
      end
   endtask

   task automatic monitor_proc();
      while (!rand_done) begin
         tick();
         if (m_if.rreq && m_if.wreq) mon_bad++;
         if ((s0_if.rack || s0_if.wack) && (s1_if.rack || s1_if.wack)) mon_bad++;
         if ((s0_if.rack && s0_if.wack) || (s1_if.rack && s1_if.wack)) mon_bad++;
         if (s0_if.rack || s0_if.wack) mon_ack0++;
         if (s1_if.rack || s1_if.wack) mon_ack1++;
      end
   endtask

   initial begin
      int          n_hi, n_tmo, tmo_cyc;
      logic        tmo_rack;
      logic [31:0] tmo_rdata;

      rst = 1'b1;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      m_if.rack = 1'b0; m_if.wack = 1'b0; m_if.rdata = '0;
      tick();
      tick();
      chk("reset_flags", out_flags(), 64'd0);
      chk("reset_maddr", 64'({m_if.raddr, m_if.waddr}), 64'd0);
      chk("reset_mwdata", 64'(m_if.wdata), 64'd0);
      chk("reset_rdata", 64'({s0_if.rdata, s1_if.rdata}), 64'd0);
      rst = 1'b0;
      tick();

      // Port 0 read, zero-wait slave
      drive(0, 1'b1, 1'b0, 14'h0, '0);
      slave_ack("rd0", 1'b0, 14'h0, '0, 32'hFEED_BABE, 0);
      chk("rd0_rack", 64'({s0_if.rack, s0_if.wack, m_if.rreq}), 64'd4);
      chk("rd0_rdata", 64'(s0_if.rdata), 64'hFEED_BABE);
      chk("rd0_s1_quiet", 64'({s1_if.rack, s1_if.wack, s1_if.rdata}), 64'd0);
      drive(0, 1'b0, 1'b0, '0, '0);
      tick();
      chk("rd0_pulse", 64'({s0_if.rack, s0_if.rdata}), 64'hFEED_BABE);
      tick();

      // Simultaneous writes: port 0 wins the first tie
      drive(0, 1'b0, 1'b1, 14'h4, 32'hAAAA_0000);
      drive(1, 1'b0, 1'b1, 14'hC, 32'hAAAA_0001);
      slave_ack("tie1_a", 1'b1, 14'h4, 32'hAAAA_0000, '0, 0);
      chk("tie1_a_ack", 64'({s0_if.wack, s1_if.wack}), 64'd2);
      drive(0, 1'b0, 1'b0, '0, '0);
      slave_ack("tie1_b", 1'b1, 14'hC, 32'hAAAA_0001, '0, 0);
      chk("tie1_b_ack", 64'({s0_if.wack, s1_if.wack}), 64'd1);
      drive(1, 1'b0, 1'b0, '0, '0);
      tick();
      tick();

      // Second tie: port 1 goes first
      drive(0, 1'b0, 1'b1, 14'h4, 32'hAAAA_0000);
      drive(1, 1'b0, 1'b1, 14'hC, 32'hAAAA_0001);
      slave_ack("tie2_a", 1'b1, 14'hC, 32'hAAAA_0001, '0, 0);
      chk("tie2_a_ack", 64'({s0_if.wack, s1_if.wack}), 64'd1);
      drive(1, 1'b0, 1'b0, '0, '0);
      slave_ack("tie2_b", 1'b1, 14'h4, 32'hAAAA_0000, '0, 1);
      chk("tie2_b_ack", 64'({s0_if.wack, s1_if.wack}), 64'd2);
      drive(0, 1'b0, 1'b0, '0, '0);
      tick();
      tick();

      // Port 1 read and write together: read first, write on the next grant
      s1_if.rreq = 1'b1; s1_if.raddr = 14'h10;
      s1_if.wreq = 1'b1; s1_if.waddr = 14'h14; s1_if.wdata = 32'h1234_5678;
      slave_ack("rw_rd", 1'b0, 14'h10, '0, 32'hCAFE_0001, 2);
      chk("rw_rd_ack", 64'({s1_if.rack, s1_if.wack}), 64'd2);
      chk("rw_rd_data", 64'({s1_if.rdata, s0_if.rdata}), {32'hCAFE_0001, 32'hFEED_BABE});
      s1_if.rreq = 1'b0;
      slave_ack("rw_wr", 1'b1, 14'h14, 32'h1234_5678, '0, 0);
      chk("rw_wr_ack", 64'({s1_if.rack, s1_if.wack}), 64'd1);
      s1_if.wreq = 1'b0;
      tick();
      tick();

      // Slave never answers: timeout completes the read
      drive(0, 1'b1, 1'b0, 14'h20, '0);
      n_hi = 0; n_tmo = 0; tmo_cyc = 0; tmo_rack = 1'b0; tmo_rdata = '0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (m_if.rreq) n_hi++;
         if (timeout) begin
            n_tmo++;
            tmo_cyc   = i;
            tmo_rack  = s0_if.rack;
            tmo_rdata = s0_if.rdata;
         end
         if (s0_if.rack) s0_if.rreq = 1'b0;
      end
      chk("tmo_mreq_cycles", 64'(n_hi), 64'(T_CYC));
      chk("tmo_pulses", 64'(n_tmo), 64'd1);
      chk("tmo_cycle", 64'(tmo_cyc), 64'(T_CYC + 1));
      chk("tmo_rack", 64'(tmo_rack), 64'd1);
      chk("tmo_rdata", 64'(tmo_rdata), 64'(TDATA));
      m_if.rdata = 32'h1111_1111;
      m_if.rack  = 1'b1;
      tick();
      tick();
      m_if.rack = 1'b0;
      chk("stray_ack_flags", out_flags(), 64'd0);
      chk("stray_ack_rdata", 64'(s0_if.rdata), 64'(TDATA));
      tick();

      // Reset while port 1's write is outstanding and port 0 is waiting
      drive(1, 1'b0, 1'b1, 14'h34, 32'h0000_0055);
      tick();
      chk("rst_issue", 64'({m_if.wreq, m_if.waddr}), 64'({1'b1, 14'h34}));
      drive(0, 1'b1, 1'b0, 14'h30, '0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_flags", out_flags(), 64'd0);
      chk("rst_maddr", 64'({m_if.raddr, m_if.waddr}), 64'd0);
      chk("rst_rdata", 64'({s0_if.rdata, s1_if.rdata}), 64'd0);
      slave_ack("rst_s0", 1'b0, 14'h30, '0, 32'h0BAD_F00D, 0);
      chk("rst_s0_ack", 64'({s0_if.rack, s1_if.wack, s0_if.rdata}), {32'h2, 32'h0BAD_F00D});
      drive(0, 1'b0, 1'b0, '0, '0);
      slave_ack("rst_s1", 1'b1, 14'h34, 32'h0000_0055, '0, 0);
      chk("rst_s1_ack", 64'(s1_if.wack), 64'd1);
      drive(1, 1'b0, 1'b0, '0, '0);
      tick();
      tick();

      // Random back-to-back traffic from both ports
      fork
         begin
            fork
               run_master(0);
               run_master(1);
            join
            rand_done = 1'b1;
         end
         slave_proc();
         monitor_proc();
      join
      chk("rand_overlap", 64'(mon_bad), 64'd0);
      chk("rand_acks_p0", 64'(mon_ack0), 64'(N_RAND));
      chk("rand_acks_p1", 64'(mon_ack1), 64'(N_RAND));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
